controlador_dma: RTL
====================

Name: controlador_dma

Overview:
- Memory-side initiator for the data memory. Copies a block of words from a source address range to a destination range in the data memory.
- Drives the memory's write enable, address and write-data inputs, and consumes its combinational read data.
- Sits beside the CPU datapath. Any memory-port arbitration between CPU and DMA is external. While busy=1 this block owns the memory port.

Parameters:
- ADDR_WIDTH, 32, width of word addresses (matches the memory address port)
- DATA_WIDTH, 32, memory word width
- LEN_WIDTH, 16, width of transfer length in words
- RAM_SIZE, 150, number of words in the target memory; used only by the bounds check

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in OCIOSO
- src  input  ADDR_WIDTH  first source word address; latched on accepted start
- dst  input  ADDR_WIDTH  first destination word address; latched on accepted start
- len  input  LEN_WIDTH  number of words to copy; latched on accepted start
- busy  output  1  high in every state except OCIOSO
- done  output  1  one-cycle pulse at end of transfer, normal or aborted
- erro  output  1  bounds violation flag
- mem_we  output  1  to memory write enable
- mem_addr  output  ADDR_WIDTH  to memory address
- mem_datain  output  DATA_WIDTH  to memory write data
- mem_dataout  input  DATA_WIDTH  from memory read data (combinational, same-cycle)

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-transfer):
  - state to OCIOSO; internal pointers, counter and buffer to 0
  - busy=0, done=0, erro=0, mem_we=0, mem_addr=0, mem_datain=0
  - an interrupted transfer is abandoned; no further writes occur
- States: OCIOSO, LER, ESCREVER, FIM. Outputs are decoded from state and registers (Moore).
- OCIOSO:
  - mem_we=0, mem_addr=0
  - start=1 at an edge latches src/dst/len into ptr_src/ptr_dst/restante and clears erro
  - next state: LER if len!=0, else FIM
- LER:
  - mem_addr=ptr_src, mem_we=0
  - at the edge, buffer<=mem_dataout, ptr_src+=1, go to ESCREVER
- ESCREVER:
  - mem_addr=ptr_dst, mem_datain=buffer, mem_we=1; the memory writes at this edge
  - at the edge, ptr_dst+=1, restante-=1
  - next state: FIM if restante==1, else LER
- FIM:
  - done=1, busy=1, mem_we=0
  - next state: OCIOSO unconditionally
- Latency: N words need 2N cycles in LER/ESCREVER plus one FIM cycle; done is high in the (2N+1)th cycle after the start edge. len=0 gives done in the first cycle after start, with no memory access.
- start while busy is ignored; it is not queued.
- Copy is strictly ascending. For overlapping ranges with dst>src, already-copied words are re-read; this is defined behaviour and not corrected.
- Pointers wrap modulo 2^ADDR_WIDTH, with no flag unless the bounds check is compiled in.
- erro holds its value through OCIOSO until the next accepted start or reset.
- mem_datain holds the buffer value in all states; only mem_we qualifies it.

Optional Feature:
- Macro DMA_BOUNDS_CHECK_EN.
- Defined:
  - in LER, if ptr_src>=RAM_SIZE: no capture, erro<=1, go to FIM
  - in ESCREVER, if ptr_dst>=RAM_SIZE: mem_we is forced to 0 that cycle, erro<=1, go to FIM
  - words already written remain written
- Not defined: erro is a constant 0 and no address comparison logic exists.

Test Plan:
- Reset mid-transfer: rst during ESCREVER of word 2 of len=4 -> mem_we=0 from the next cycle, busy=0, dst+2 and dst+3 unchanged.
- Basic copy: memory[10..13]=A,B,C,D, start with src=10, dst=40, len=4 -> memory[40..43]=A,B,C,D; done pulses exactly 9 cycles after the start edge; busy high for cycles 1..9.
- Zero length: start with len=0 -> done in cycle 1, mem_we never asserted, busy high for 1 cycle.
- Start while busy: second start with src=0 during a len=3 copy -> ignored; only the first transfer's 3 writes occur.
- Overlap: memory[5]=7, memory[6]=8, src=5, dst=6, len=2 -> memory[6]=7, memory[7]=7.
- DMA_BOUNDS_CHECK_EN: src=0, dst=148, len=4, RAM_SIZE=150 -> words 148 and 149 written, no write at 150, erro=1 and done pulses after the third read; erro stays 1 until the next start.

Source files
------------

// File: rtl/controlador_dma.sv
// Block-copy DMA initiator for the data memory: alternates read/write cycles from src to dst.
// Optional bounds check against RAM_SIZE is compiled in with DMA_BOUNDS_CHECK_EN.
module controlador_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int RAM_SIZE   = 150
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  erro,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] LER      = 2'd1;
  localparam logic [1:0] ESCREVER = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  if (RAM_SIZE < 1) begin : g_ram_size_chk
    $error("RAM_SIZE must be at least 1");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_src_q, ptr_src_d;
  logic [ADDR_WIDTH-1:0] ptr_dst_q, ptr_dst_d;
  logic [LEN_WIDTH-1:0]  restante_q, restante_d;
  logic [DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic                  erro_q, erro_d;
  logic                  src_oob, dst_oob;

`ifdef DMA_BOUNDS_CHECK_EN
  assign src_oob = (ptr_src_q >= ADDR_WIDTH'(RAM_SIZE));
  assign dst_oob = (ptr_dst_q >= ADDR_WIDTH'(RAM_SIZE));
`else
  assign src_oob = 1'b0;
  assign dst_oob = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_src_d  = ptr_src_q;
    ptr_dst_d  = ptr_dst_q;
    restante_d = restante_q;
    buffer_d   = buffer_q;
    erro_d     = erro_q;
    case (state_q)
      OCIOSO: begin
        if (start) begin
          ptr_src_d  = src;
          ptr_dst_d  = dst;
          restante_d = len;
          erro_d     = 1'b0;
          state_d    = (len != '0) ? LER : FIM;
        end
      end
      LER: begin
        if (src_oob) begin
          erro_d  = 1'b1;
          state_d = FIM;
        end else begin
          buffer_d  = mem_dataout;
          ptr_src_d = ptr_src_q + ADDR_WIDTH'(1);
          state_d   = ESCREVER;
        end
      end
      ESCREVER: begin
        if (dst_oob) begin
          erro_d  = 1'b1;
          state_d = FIM;
        end else begin
          ptr_dst_d  = ptr_dst_q + ADDR_WIDTH'(1);
          restante_d = restante_q - LEN_WIDTH'(1);
          state_d    = (restante_q == LEN_WIDTH'(1)) ? FIM : LER;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OCIOSO;
      ptr_src_q  <= '0;
      ptr_dst_q  <= '0;
      restante_q <= '0;
      buffer_q   <= '0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_src_q  <= ptr_src_d;
      ptr_dst_q  <= ptr_dst_d;
      restante_q <= restante_d;
      buffer_q   <= buffer_d;
      erro_q     <= erro_d;
    end
  end

  // Moore outputs; write data is the buffer at all times, only mem_we qualifies it
  assign busy       = (state_q != OCIOSO);
  assign done       = (state_q == FIM);
  assign erro       = erro_q;
  assign mem_we     = (state_q == ESCREVER) && !dst_oob;
  assign mem_datain = buffer_q;

  always_comb begin
    mem_addr = '0;
    case (state_q)
      LER:      mem_addr = ptr_src_q;
      ESCREVER: mem_addr = ptr_dst_q;
      default:  mem_addr = '0;
    endcase
  end

endmodule
